fb_sram_mc: RTL and testbench

Multi-channel framebuffer SRAM. It holds NUM_CH independent colour planes (R/G/B by default) that share one address space. Writes are byte-granular with a per-channel mask, reads have one cycle of latency with a valid strobe and write-first collision forwarding, and a built-in clear engine fills every plane with a constant. It sits between the FIFO->SRAM writer and the display/readback pipeline and replaces the per-colour single-plane SRAMs.

---
 rtl/fb_sram_mc.sv | 124 ++++++++++++
 tb/tb_fb_sram_mc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_sram_mc.sv
// Multi-plane framebuffer SRAM: byte-masked writes, 1-cycle write-first reads, built-in clear engine.
// Clear owns the write port for DEPTH cycles (external writes dropped); reads are always served.
module fb_sram_mc #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int NUM_CH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [NUM_CH-1:0]          wr_ch_mask,
  input  logic [DATA_W/8-1:0]        wr_be,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [NUM_CH*DATA_W-1:0]   wr_data,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [NUM_CH*DATA_W-1:0]   rd_data,
  output logic                       rd_valid,
  input  logic                       clr_start,
  input  logic [DATA_W-1:0]          clr_data,
  output logic                       clr_busy,
  output logic                       clr_done
);
  localparam int NB = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W:0]     cnt;
  logic [DATA_W-1:0]   clr_val;
  logic                done_q;
  logic                at_last;

  logic [NUM_CH-1:0]        w_ch;
  logic [NB-1:0]            w_be;
  logic [ADDR_W-1:0]        w_addr;
  logic [NUM_CH*DATA_W-1:0] w_dat;

  assign at_last = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_start) state_nxt = CLEAR;
      CLEAR:   if (at_last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clr_busy = (state == CLEAR);
    clr_done = done_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == CLEAR) && at_last;
      if (state == IDLE && clr_start) begin
        cnt     <= '0;
        clr_val <= clr_data;
      end else if (state == CLEAR) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Single write port shared by the clear engine and the external writer; reset blocks all writes.
  always_comb begin
    if (state == CLEAR) begin
      w_ch   = {NUM_CH{1'b1}};
      w_be   = {NB{1'b1}};
      w_addr = cnt[ADDR_W-1:0];
      w_dat  = {NUM_CH{clr_val}};
    end else begin
      w_ch   = wr_en ? wr_ch_mask : '0;
      w_be   = wr_be;
      w_addr = wr_addr;
      w_dat  = wr_data;
    end
    if (rst) w_ch = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_valid <= 1'b0;
    else     rd_valid <= rd_en;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] fwd_w;
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++)
        if (w_ch[c] && w_be[b]) mem[w_addr][b*8 +: 8] <= w_dat[c*DATA_W + b*8 +: 8];
    end

    // Write-first: bytes being written this cycle replace the stored ones on a same-address read.
    always_comb begin
      fwd_w = mem[rd_addr];
      for (int b = 0; b < NB; b++)
        if (w_ch[c] && w_be[b] && (w_addr == rd_addr))
          fwd_w[b*8 +: 8] = w_dat[c*DATA_W + b*8 +: 8];
    end

    always_ff @(posedge clk) begin
      if (rst)        rd_q <= '0;
      else if (rd_en) rd_q <= fwd_w;
    end

    assign rd_data[c*DATA_W +: DATA_W] = rd_q;
  end

endmodule

// File: tb/tb_fb_sram_mc.sv
// Bench for fb_sram_mc at ADDR_W=4: vector table, hand-written clear/reset sequences, random vs array model.
module tb_fb_sram_mc;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NC = 3;
  localparam int D  = 1 << AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [NC-1:0]     wr_ch_mask;
  logic [DW/8-1:0]   wr_be;
  logic [AW-1:0]     wr_addr;
  logic [NC*DW-1:0]  wr_data;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [NC*DW-1:0]  rd_data;
  logic              rd_valid;
  logic              clr_start;
  logic [DW-1:0]     clr_data;
  logic              clr_busy;
  logic              clr_done;

  fb_sram_mc #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NC)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch_mask(wr_ch_mask), .wr_be(wr_be),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .clr_start(clr_start), .clr_data(clr_data),
    .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] model [NC][D];

  typedef struct {
    logic          we;
    logic [NC-1:0] mask;
    logic [3:0]    be;
    logic [AW-1:0] waddr;
    logic [95:0]   wdata;
    logic          re;
    logic [AW-1:0] raddr;
    logic          exp_valid;
    logic          chk_data;
    logic [95:0]   exp_data;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(input logic we, input logic [NC-1:0] mask, input logic [3:0] be,
                              input logic [AW-1:0] waddr, input logic [95:0] wdata,
                              input logic re, input logic [AW-1:0] raddr,
                              input logic exp_valid, input logic chk_data, input logic [95:0] exp_data);
    vec_t v;
    v.we = we; v.mask = mask; v.be = be; v.waddr = waddr; v.wdata = wdata;
    v.re = re; v.raddr = raddr; v.exp_valid = exp_valid; v.chk_data = chk_data; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_ch_mask = '0; wr_be = '0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; clr_start = 1'b0; clr_data = '0;
  endtask

  function automatic logic [95:0] model_word(input logic [AW-1:0] a);
    return {model[2][a], model[1][a], model[0][a]};
  endfunction

  task automatic model_wr(input logic [NC-1:0] mask, input logic [3:0] be,
                          input logic [AW-1:0] a, input logic [95:0] d);
    for (int c = 0; c < NC; c++)
      for (int b = 0; b < 4; b++)
        if (mask[c] && be[b]) model[c][a][b*8 +: 8] = d[c*DW + b*8 +: 8];
  endtask

  task automatic model_fill(input int upto, input logic [DW-1:0] v);
    for (int c = 0; c < NC; c++)
      for (int a = 0; a < upto; a++) model[c][a] = v;
  endtask

  task automatic read_all(input string nm);
    for (int a = 0; a < D; a++) begin
      idle_inputs();
      rd_en = 1'b1; rd_addr = AW'(a);
      tick();
      chk({nm, "_valid"}, {95'd0, rd_valid}, 96'd1);
      chk(nm, rd_data, model_word(AW'(a)));
    end
    idle_inputs();
  endtask

  initial begin
    logic [95:0] exp_rd;
    logic        we, re;
    logic [NC-1:0] m;
    logic [3:0]  be;
    logic [AW-1:0] wa, ra;
    logic [95:0] wd;

    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_rd_data", rd_data, '0);
    chk("reset_rd_valid", {95'd0, rd_valid}, '0);
    chk("reset_busy", {95'd0, clr_busy}, '0);
    chk("reset_done", {95'd0, clr_done}, '0);

    // Clear engine with an ignored write at N+2, a read of the live clear address, and a second start.
    clr_start = 1'b1; clr_data = 32'h5A5A5A5A;
    tick();
    idle_inputs();
    for (int k = 1; k <= 18; k++) begin
      chk("clr_busy", {95'd0, clr_busy}, {95'd0, (k <= 16)});
      chk("clr_done", {95'd0, clr_done}, {95'd0, (k == 17)});
      if (k == 4) begin
        chk("clr_fwd_valid", {95'd0, rd_valid}, 96'd1);
        chk("clr_fwd_data", rd_data, {3{32'h5A5A5A5A}});
      end
      idle_inputs();
      if (k == 2) begin
        wr_en = 1'b1; wr_ch_mask = 3'b111; wr_be = 4'hF; wr_addr = 4'h3; wr_data = {3{32'h12345678}};
      end
      if (k == 3) begin
        rd_en = 1'b1; rd_addr = 4'h2;
      end
      if (k == 5) begin
        clr_start = 1'b1; clr_data = 32'h0;
      end
      tick();
    end
    idle_inputs();
    model_fill(D, 32'h5A5A5A5A);
    read_all("clear_readback");

    // Vector table: byte-mask write, collision forwarding, back-to-back read pipeline.
    vt[0]  = mk(1'b1, 3'b111, 4'hF, 4'h5, {3{32'h11223344}}, 1'b0, 4'h0, 1'b0, 1'b0, '0);
    vt[1]  = mk(1'b1, 3'b010, 4'b0101, 4'h5, {32'h0, 32'hAABBCCDD, 32'h0}, 1'b0, 4'h0, 1'b0, 1'b0, '0);
    vt[2]  = mk(1'b0, 3'b000, 4'h0, 4'h0, '0, 1'b1, 4'h5, 1'b1, 1'b1,
                {32'h11223344, 32'h11BB33DD, 32'h11223344});
    vt[3]  = mk(1'b0, 3'b000, 4'h0, 4'h0, '0, 1'b0, 4'h0, 1'b0, 1'b0, '0);
    vt[4]  = mk(1'b1, 3'b111, 4'hF, 4'hA, '0, 1'b0, 4'h0, 1'b0, 1'b0, '0);
    vt[5]  = mk(1'b1, 3'b111, 4'b1000, 4'hA, {3{32'hFFFFFFFF}}, 1'b1, 4'hA, 1'b1, 1'b1, {3{32'hFF000000}});
    vt[6]  = mk(1'b0, 3'b000, 4'h0, 4'h0, '0, 1'b1, 4'hA, 1'b1, 1'b1, {3{32'hFF000000}});
    vt[7]  = mk(1'b1, 3'b111, 4'hF, 4'h0, {32'hB0000000, 32'hC0000000, 32'hA0000000}, 1'b0, 4'h0, 1'b0, 1'b0, '0);
    vt[8]  = mk(1'b1, 3'b111, 4'hF, 4'h1, {32'hB0000001, 32'hC0000001, 32'hA0000001}, 1'b0, 4'h0, 1'b0, 1'b0, '0);
    vt[9]  = mk(1'b1, 3'b111, 4'hF, 4'h2, {32'hB0000002, 32'hC0000002, 32'hA0000002}, 1'b0, 4'h0, 1'b0, 1'b0, '0);
    vt[10] = mk(1'b0, 3'b000, 4'h0, 4'h0, '0, 1'b1, 4'h0, 1'b1, 1'b1, {32'hB0000000, 32'hC0000000, 32'hA0000000});
    vt[11] = mk(1'b0, 3'b000, 4'h0, 4'h0, '0, 1'b1, 4'h1, 1'b1, 1'b1, {32'hB0000001, 32'hC0000001, 32'hA0000001});
    vt[12] = mk(1'b0, 3'b000, 4'h0, 4'h0, '0, 1'b1, 4'h2, 1'b1, 1'b1, {32'hB0000002, 32'hC0000002, 32'hA0000002});
    vt[13] = mk(1'b0, 3'b000, 4'h0, 4'h0, '0, 1'b0, 4'h0, 1'b0, 1'b1, {32'hB0000002, 32'hC0000002, 32'hA0000002});

    for (int i = 0; i < 14; i++) begin
      idle_inputs();
      wr_en = vt[i].we; wr_ch_mask = vt[i].mask; wr_be = vt[i].be;
      wr_addr = vt[i].waddr; wr_data = vt[i].wdata;
      rd_en = vt[i].re; rd_addr = vt[i].raddr;
      if (vt[i].we) model_wr(vt[i].mask, vt[i].be, vt[i].waddr, vt[i].wdata);
      tick();
      chk($sformatf("vec%0d_valid", i), {95'd0, rd_valid}, {95'd0, vt[i].exp_valid});
      if (vt[i].chk_data) chk($sformatf("vec%0d_data", i), rd_data, vt[i].exp_data);
    end
    idle_inputs();

    // Clear started together with a write to 0x9, then reset at N+6 alongside a read.
    clr_start = 1'b1; clr_data = 32'hC3C3C3C3;
    wr_en = 1'b1; wr_ch_mask = 3'b111; wr_be = 4'hF; wr_addr = 4'h9; wr_data = {3{32'h99887766}};
    model_wr(3'b111, 4'hF, 4'h9, {3{32'h99887766}});
    tick();
    idle_inputs();
    for (int k = 1; k <= 5; k++) tick();
    rst = 1'b1; rd_en = 1'b1; rd_addr = 4'h1;
    tick();
    rst = 1'b0; idle_inputs();
    chk("rstmid_busy", {95'd0, clr_busy}, '0);
    chk("rstmid_valid", {95'd0, rd_valid}, '0);
    chk("rstmid_rd_data", rd_data, '0);
    for (int k = 0; k < 20; k++) begin
      chk("rstmid_no_done", {95'd0, clr_done}, '0);
      tick();
    end
    model_fill(5, 32'hC3C3C3C3);
    read_all("rstmid_readback");

    // Random traffic against the array model; a write-first read is model-write then model-read.
    exp_rd = rd_data;
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1));
      m  = NC'($urandom);
      be = 4'($urandom);
      wa = AW'($urandom);
      wd = {$urandom, $urandom, $urandom};
      re = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
      idle_inputs();
      wr_en = we; wr_ch_mask = m; wr_be = be; wr_addr = wa; wr_data = wd;
      rd_en = re; rd_addr = ra;
      if (we) model_wr(m, be, wa, wd);
      if (re) exp_rd = model_word(ra);
      tick();
      chk("rand_valid", {95'd0, rd_valid}, {95'd0, re});
      chk("rand_data", rd_data, exp_rd);
    end
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
